// File: rtl/uart_rx_frame_ctrl.sv
// UART receive-path controller: baud tick generation, rx_ready edge detect, and
// SYNC/LEN/payload/CHK frame parsing into a held payload buffer with error reporting.
module uart_rx_frame_ctrl #(
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       baud_tick,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       frame_valid,
   output logic [4:0] frame_len,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       frame_ack,
   output logic       chk_err,
   output logic       len_err,
   output logic       timeout_err,
   output logic       overrun_err,
   output logic [7:0] err_count
);

   localparam int unsigned BAUD_W = $clog2(CLK_DIV);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned BUF_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              rx_ready_q;
   logic [4:0]        len_q, len_d;
   logic [4:0]        idx_q, idx_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        buf_q [MAX_LEN];
   logic              byte_stb;
   logic              wr_en;
   logic              valid_d;
   logic [4:0]        flen_d;
   logic              chk_err_d, len_err_d, timeout_err_d, overrun_err_d, any_err;

   // Next-state, datapath and error decode
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      idx_d         = idx_q;
      chk_d         = chk_q;
      to_cnt_d      = '0;
      wr_en         = 1'b0;
      valid_d       = frame_valid;
      flen_d        = frame_len;
      chk_err_d     = 1'b0;
      len_err_d     = 1'b0;
      timeout_err_d = 1'b0;
      overrun_err_d = 1'b0;
      byte_stb      = rx_ready & ~rx_ready_q;

      baud_cnt_d = '0;
      if (enable && baud_cnt_q != BAUD_W'(CLK_DIV - 1))
         baud_cnt_d = baud_cnt_q + BAUD_W'(1);

      case (state_q)
         IDLE: begin
            if (byte_stb && rx_data == SYNC_BYTE) state_d = LEN;
         end
         LEN: begin
            if (byte_stb) begin
               if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                  len_err_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  len_d   = rx_data[4:0];
                  chk_d   = rx_data;
                  idx_d   = 5'd0;
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (byte_stb) begin
               wr_en = 1'b1;
               chk_d = chk_q ^ rx_data;
               idx_d = idx_q + 5'd1;
               if (idx_q == len_q - 5'd1) state_d = CHK;
            end
         end
         CHK: begin
            if (byte_stb) begin
               if (rx_data == chk_q) begin
                  valid_d = 1'b1;
                  flen_d  = len_q;
                  state_d = HOLD;
               end else begin
                  chk_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         HOLD: begin
            // Ack wins over a coincident byte, which is then parsed as from IDLE
            if (frame_ack) begin
               valid_d = 1'b0;
               state_d = (byte_stb && rx_data == SYNC_BYTE) ? LEN : IDLE;
            end else if (byte_stb) begin
               overrun_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q == LEN || state_q == PAYLOAD || state_q == CHK) begin
         if (byte_stb) begin
            to_cnt_d = '0;
         end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end

      if (!enable) begin
         state_d       = IDLE;
         to_cnt_d      = '0;
         wr_en         = 1'b0;
         valid_d       = 1'b0;
         chk_err_d     = 1'b0;
         len_err_d     = 1'b0;
         timeout_err_d = 1'b0;
         overrun_err_d = 1'b0;
      end

      any_err = chk_err_d | len_err_d | timeout_err_d | overrun_err_d;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         baud_cnt_q  <= '0;
         baud_tick   <= 1'b0;
         to_cnt_q    <= '0;
         rx_ready_q  <= 1'b0;
         len_q       <= '0;
         idx_q       <= '0;
         chk_q       <= '0;
         frame_valid <= 1'b0;
         frame_len   <= '0;
         rd_data     <= '0;
         chk_err     <= 1'b0;
         len_err     <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         err_count   <= '0;
         for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
      end else begin
         baud_cnt_q  <= baud_cnt_d;
         baud_tick   <= enable && (baud_cnt_d == BAUD_W'(CLK_DIV - 1));
         to_cnt_q    <= to_cnt_d;
         rx_ready_q  <= rx_ready;
         len_q       <= len_d;
         idx_q       <= idx_d;
         chk_q       <= chk_d;
         frame_valid <= valid_d;
         frame_len   <= flen_d;
         chk_err     <= chk_err_d;
         len_err     <= len_err_d;
         timeout_err <= timeout_err_d;
         overrun_err <= overrun_err_d;
         if (any_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (wr_en) buf_q[BUF_W'(idx_q)] <= rx_data;
         if (rd_addr < 5'(MAX_LEN)) rd_data <= buf_q[BUF_W'(rd_addr)];
         else                       rd_data <= 8'd0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: baud ticks, frame accept/reject paths,
// overrun, ack/byte collision and mid-frame reset.
module tb_uart_rx_frame_ctrl;

   localparam int unsigned TIMEOUT = 1024;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       baud_tick;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready = 1'b0;
   logic       frame_valid;
   logic [4:0] frame_len;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       frame_ack = 1'b0;
   logic       chk_err, len_err, timeout_err, overrun_err;
   logic [7:0] err_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_chk  = 0;
   int n_len  = 0;
   int n_to   = 0;
   int n_ovr  = 0;
   logic [7:0] exp_errs = 8'd0;

   uart_rx_frame_ctrl #(.CLK_DIV(4), .MAX_LEN(16), .TIMEOUT(TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .enable(enable), .baud_tick(baud_tick),
      .rx_data(rx_data), .rx_ready(rx_ready), .frame_valid(frame_valid),
      .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data),
      .frame_ack(frame_ack), .chk_err(chk_err), .len_err(len_err),
      .timeout_err(timeout_err), .overrun_err(overrun_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Pulse tallies sampled mid-cycle
   always @(negedge clk) begin
      n_chk = n_chk + int'(chk_err);
      n_len = n_len + int'(len_err);
      n_to  = n_to  + int'(timeout_err);
      n_ovr = n_ovr + int'(overrun_err);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      cyc(8);
      rx_ready = 1'b0;
      cyc(2);
   endtask

   task automatic do_ack();
      frame_ack = 1'b1;
      cyc(1);
      frame_ack = 1'b0;
      cyc(1);
      n_cmp++;
      if (frame_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_clears_valid: got %0b want 0", frame_valid);
      end
   endtask

   task automatic check_rd(input string name, input logic [4:0] a, input logic [7:0] e);
      rd_addr = a;
      cyc(1);
      n_cmp++;
      if (rd_data !== e) begin
         n_fail++;
         $display("FAIL %s: rd_data[%0d] got %h want %h", name, a, rd_data, e);
      end
   endtask

   task automatic check_held(input string name, input logic [4:0] len);
      n_cmp++;
      if ({frame_valid, frame_len} !== {1'b1, len}) begin
         n_fail++;
         $display("FAIL %s: valid/len got %0b/%0d want 1/%0d", name, frame_valid, frame_len, len);
      end
      n_cmp++;
      if (err_count !== exp_errs) begin
         n_fail++;
         $display("FAIL %s_errcnt: got %0d want %0d", name, err_count, exp_errs);
      end
   endtask

   task automatic test_reset();
      cyc(3);
      n_cmp++;
      if ({baud_tick, frame_valid, frame_len, rd_data, chk_err, len_err, timeout_err,
           overrun_err, err_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: tick=%0b valid=%0b len=%0d rd=%h errs=%0b%0b%0b%0b cnt=%0d want all 0",
                  baud_tick, frame_valid, frame_len, rd_data, chk_err, len_err, timeout_err,
                  overrun_err, err_count);
      end
   endtask

   task automatic test_baud();
      logic e;
      reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         e = ((k % 4) == 3);
         n_cmp++;
         if (baud_tick !== e) begin
            n_fail++;
            $display("FAIL baud_tick_cycle%0d: got %0b want %0b", k, baud_tick, e);
         end
      end
      enable = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_cmp++;
         if (baud_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL baud_disabled_cycle%0d: got %0b want 0", k, baud_tick);
         end
      end
      enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         e = (k == 3);
         n_cmp++;
         if (baud_tick !== e) begin
            n_fail++;
            $display("FAIL baud_restart_cycle%0d: got %0b want %0b", k, baud_tick, e);
         end
      end
   endtask

   task automatic test_good_frame();
      int base;
      base = n_chk + n_len + n_to + n_ovr;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      check_held("good", 5'd3);
      check_rd("good_rd0", 5'd0, 8'h11);
      check_rd("good_rd1", 5'd1, 8'h22);
      check_rd("good_rd2", 5'd2, 8'h33);
      check_rd("good_rd_oob", 5'd16, 8'h00);
      n_cmp++;
      if (n_chk + n_len + n_to + n_ovr - base !== 0) begin
         n_fail++;
         $display("FAIL good_no_errors: got %0d pulses want 0", n_chk + n_len + n_to + n_ovr - base);
      end
      do_ack();
   endtask

   task automatic test_chk_err();
      int base;
      base = n_chk;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      send_byte(8'h20); send_byte(8'h31);
      exp_errs = exp_errs + 8'd1;
      n_cmp++;
      if (n_chk - base !== 1) begin
         n_fail++;
         $display("FAIL chk_err_pulses: got %0d want 1", n_chk - base);
      end
      n_cmp++;
      if ({frame_valid, err_count} !== {1'b0, exp_errs}) begin
         n_fail++;
         $display("FAIL chk_err_state: valid/cnt got %0b/%0d want 0/%0d", frame_valid, err_count, exp_errs);
      end
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h7E);
      check_held("after_chk", 5'd1);
      check_rd("after_chk_rd0", 5'd0, 8'h7F);
      do_ack();
   endtask

   task automatic test_len_err();
      int base;
      base = n_len;
      send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h11);
      exp_errs = exp_errs + 8'd2;
      n_cmp++;
      if (n_len - base !== 2) begin
         n_fail++;
         $display("FAIL len_err_pulses: got %0d want 2", n_len - base);
      end
      n_cmp++;
      if ({frame_valid, err_count} !== {1'b0, exp_errs}) begin
         n_fail++;
         $display("FAIL len_err_state: valid/cnt got %0b/%0d want 0/%0d", frame_valid, err_count, exp_errs);
      end
   endtask

   task automatic test_timeout();
      int base;
      base = n_to;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      cyc(TIMEOUT + 20);
      exp_errs = exp_errs + 8'd1;
      n_cmp++;
      if (n_to - base !== 1) begin
         n_fail++;
         $display("FAIL timeout_pulses: got %0d want 1", n_to - base);
      end
      n_cmp++;
      if ({frame_valid, err_count} !== {1'b0, exp_errs}) begin
         n_fail++;
         $display("FAIL timeout_state: valid/cnt got %0b/%0d want 0/%0d", frame_valid, err_count, exp_errs);
      end
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
      send_byte(8'hBB); send_byte(8'h13);
      check_held("after_to", 5'd2);
      check_rd("after_to_rd1", 5'd1, 8'hBB);
      do_ack();
   endtask

   task automatic test_overrun_and_collision();
      int base;
      base = n_ovr;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      check_held("pre_ovr", 5'd1);
      send_byte(8'h55);
      exp_errs = exp_errs + 8'd1;
      n_cmp++;
      if (n_ovr - base !== 1) begin
         n_fail++;
         $display("FAIL overrun_pulses: got %0d want 1", n_ovr - base);
      end
      check_held("post_ovr", 5'd1);
      check_rd("post_ovr_rd0", 5'd0, 8'h5A);
      // Ack lands in the same cycle as the SYNC strobe
      rx_data   = 8'hA5;
      rx_ready  = 1'b1;
      frame_ack = 1'b1;
      cyc(1);
      frame_ack = 1'b0;
      cyc(7);
      rx_ready = 1'b0;
      cyc(2);
      n_cmp++;
      if ({frame_valid, 32'(n_ovr - base)} !== {1'b0, 32'd1}) begin
         n_fail++;
         $display("FAIL ack_collision: valid/overruns got %0b/%0d want 0/1", frame_valid, n_ovr - base);
      end
      send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
      check_held("collision_frame", 5'd1);
      check_rd("collision_rd0", 5'd0, 8'h44);
      do_ack();
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      reset = 1'b0;
      cyc(2);
      exp_errs = 8'd0;
      n_cmp++;
      if ({baud_tick, frame_valid, frame_len, rd_data, chk_err, len_err, timeout_err,
           overrun_err, err_count} !== '0) begin
         n_fail++;
         $display("FAIL midframe_reset: valid=%0b len=%0d rd=%h cnt=%0d want all 0",
                  frame_valid, frame_len, rd_data, err_count);
      end
      reset = 1'b1;
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      n_cmp++;
      if ({frame_valid, err_count} !== 9'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: valid/cnt got %0b/%0d want 0/0", frame_valid, err_count);
      end
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h7E);
      check_held("post_reset_frame", 5'd1);
      check_rd("post_reset_rd0", 5'd0, 8'h7F);
      do_ack();
   endtask

   initial begin
      test_reset();
      test_baud();
      test_good_frame();
      test_chk_err();
      test_len_err();
      test_timeout();
      test_overrun_and_collision();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
